// File: rtl/elementwise_pkg.sv
// Shared types for the element-wise stream engine: operation codes, FSM states
// and the saturation range check used by every lane.
package elementwise_pkg;

  typedef enum logic [2:0] {
    EW_ADD = 3'd0,
    EW_SUB = 3'd1,
    EW_MUL = 3'd2,
    EW_MAX = 3'd3,
    EW_MIN = 3'd4
  } ew_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ew_state_e;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_HI   = 2'd1,
    SAT_LO   = 2'd2
  } sat_dir_e;

  // Reports whether a wide signed value falls outside the dw-bit signed range.
  function automatic sat_dir_e sat_check(input logic signed [63:0] v, input int unsigned dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) begin
      return SAT_HI;
    end
    if (v < lo) begin
      return SAT_LO;
    end
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/elementwise_stream_engine_if.sv
// Handshake bundle for the engine: two operand streams in, one result stream out.
interface elementwise_stream_engine_if #(
  parameter int LANES = 32,
  parameter int DW    = 16
);
  logic                  a_valid;
  logic                  a_ready;
  logic [LANES*DW-1:0]   a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [LANES*DW-1:0]   b_data;
  logic                  o_valid;
  logic                  o_ready;
  logic [LANES*DW-1:0]   o_data;
  logic                  o_last;

  modport master (
    output a_valid, a_data, b_valid, b_data, o_ready,
    input  a_ready, b_ready, o_valid, o_data, o_last
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, o_ready,
    output a_ready, b_ready, o_valid, o_data, o_last
  );
endinterface

// File: rtl/elementwise_lane_alu.sv
// One lane of the engine: raw operation (first stage) and round/saturate/ReLU
// (second stage) as two independent combinational paths; the parent registers between them.
module elementwise_lane_alu
  import elementwise_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [2:0]      mode,
  input  logic [4:0]      mul_shift,
  input  logic            relu_en,
  output logic [2*DW-1:0] raw,
  input  logic [2*DW-1:0] raw_in,
  output logic [DW-1:0]   res,
  output logic            clip
);
  localparam int RW = 2 * DW;

  logic signed [RW-1:0] ax;
  logic signed [RW-1:0] bx;
  logic signed [RW:0]   wide;
  logic signed [63:0]   v64;
  sat_dir_e             dir;
  logic [DW-1:0]        sat_val;

  // Every mode is carried at 2*DW so that stage two handles all of them uniformly.
  always_comb begin
    ax = {{DW{a[DW-1]}}, a};
    bx = {{DW{b[DW-1]}}, b};
    case (mode)
      EW_ADD:  raw = ax + bx;
      EW_SUB:  raw = ax - bx;
      EW_MUL:  raw = ax * bx;
      EW_MAX:  raw = (ax > bx) ? ax : bx;
      EW_MIN:  raw = (ax < bx) ? ax : bx;
      default: raw = ax;
    endcase
  end

  // One extra bit keeps the rounding increment from overflowing a full-scale product.
  always_comb begin
    wide = {raw_in[RW-1], raw_in};
    if (mode == EW_MUL) begin
      if (mul_shift != 5'd0) begin
        wide = wide + ((RW + 1)'(1) << (mul_shift - 5'd1));
      end
      wide = wide >>> mul_shift;
    end
    v64  = {{(63 - RW){wide[RW]}}, wide};
    dir  = sat_check(v64, DW);
    clip = (dir != SAT_NONE);
    case (dir)
      SAT_HI:  sat_val = {1'b0, {(DW - 1){1'b1}}};
      SAT_LO:  sat_val = {1'b1, {(DW - 1){1'b0}}};
      default: sat_val = wide[DW-1:0];
    endcase
    res = (relu_en && sat_val[DW-1]) ? '0 : sat_val;
  end

endmodule

// File: rtl/elementwise_stream_engine.sv
// Streaming element-wise engine: combines A and B (or a broadcast scalar) lane by lane
// through a two-stage pipeline and emits pix_cnt result beats per run.
module elementwise_stream_engine
  import elementwise_pkg::*;
#(
  parameter int LANES = 32,
  parameter int DW    = 16,
  parameter int CNT_W = 24
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [2:0]                  mode,
  input  logic                        relu_en,
  input  logic                        b_bcast,
  input  logic [DW-1:0]               b_scalar,
  input  logic [4:0]                  mul_shift,
  input  logic [CNT_W-1:0]            pix_cnt,
  elementwise_stream_engine_if.slave  strm,
  output logic                        busy,
  output logic                        done,
  output logic                        sat_flag
);
  localparam int RW = 2 * DW;

  ew_state_e state, state_next;

  logic [2:0]            mode_q;
  logic                  relu_q;
  logic                  bcast_q;
  logic [DW-1:0]         bscalar_q;
  logic [4:0]            shift_q;
  logic [CNT_W-1:0]      pix_cnt_q;
  logic [CNT_W-1:0]      in_cnt;
  logic [CNT_W-1:0]      out_cnt;

  logic                  s1_valid;
  logic                  s2_valid;
  logic [LANES*RW-1:0]   s1_raw;
  logic [LANES*DW-1:0]   s2_data;
  logic [LANES*RW-1:0]   raw_w;
  logic [LANES*DW-1:0]   res_w;
  logic [LANES-1:0]      clip_w;

  logic adv, in_open, a_rdy, b_rdy, fire, out_fire, last_in, last_out, start_acc;

  // All stages move together: S2 can only be overwritten once its beat has left.
  assign adv       = !s2_valid || strm.o_ready;
  assign in_open   = (state == ST_RUN) && adv && (in_cnt < pix_cnt_q);
  assign a_rdy     = in_open && (bcast_q || strm.b_valid);
  assign b_rdy     = in_open && strm.a_valid && !bcast_q;
  assign fire      = a_rdy && strm.a_valid;
  assign out_fire  = s2_valid && strm.o_ready;
  assign last_in   = (in_cnt == pix_cnt_q - 1'b1);
  assign last_out  = (out_cnt == pix_cnt_q - 1'b1);
  assign start_acc = (state == ST_IDLE) && start;

  assign strm.a_ready = a_rdy;
  assign strm.b_ready = b_rdy;
  assign strm.o_valid = s2_valid;
  assign strm.o_data  = s2_data;
  assign strm.o_last  = s2_valid && last_out;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DW-1:0] b_lane;
      assign b_lane = bcast_q ? bscalar_q : strm.b_data[gi*DW +: DW];

      elementwise_lane_alu #(.DW(DW)) u_alu (
        .a         (strm.a_data[gi*DW +: DW]),
        .b         (b_lane),
        .mode      (mode_q),
        .mul_shift (shift_q),
        .relu_en   (relu_q),
        .raw       (raw_w[gi*RW +: RW]),
        .raw_in    (s1_raw[gi*RW +: RW]),
        .res       (res_w[gi*DW +: DW]),
        .clip      (clip_w[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = (pix_cnt == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (fire && last_in) state_next = ST_DRAIN;
      ST_DRAIN: if (out_fire && last_out) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN) || (state == ST_DRAIN);
    done = (state == ST_DONE);
  end

  // Run configuration is frozen at launch; live config inputs are ignored afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= '0;
      relu_q    <= 1'b0;
      bcast_q   <= 1'b0;
      bscalar_q <= '0;
      shift_q   <= '0;
      pix_cnt_q <= '0;
    end else if (start_acc) begin
      mode_q    <= mode;
      relu_q    <= relu_en;
      bcast_q   <= b_bcast;
      bscalar_q <= b_scalar;
      shift_q   <= mul_shift;
      pix_cnt_q <= pix_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt   <= '0;
      out_cnt  <= '0;
      sat_flag <= 1'b0;
    end else if (start_acc) begin
      in_cnt   <= '0;
      out_cnt  <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (fire)     in_cnt  <= in_cnt + 1'b1;
      if (out_fire) out_cnt <= out_cnt + 1'b1;
      if (adv && s1_valid && (|clip_w)) sat_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_raw   <= '0;
      s2_data  <= '0;
    end else if (adv) begin
      s1_valid <= fire;
      s2_valid <= s1_valid;
      if (fire)     s1_raw  <= raw_w;
      if (s1_valid) s2_data <= res_w;
    end
  end

endmodule

// File: tb/tb_elementwise_stream_engine.sv
// Directed bench: table of single-beat vectors plus multi-beat runs covering
// latency, backpressure, broadcast, empty runs and reset mid-run.
module tb_elementwise_stream_engine;
  import elementwise_pkg::*;

  localparam int LANES = 32;
  localparam int DW    = 16;
  localparam int CNT_W = 24;
  localparam int W     = LANES * DW;

  typedef struct {
    logic [2:0]  mode;
    logic        relu;
    logic        bcast;
    logic [15:0] bsc;
    logic [4:0]  sh;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    logic        sat;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       cfg_mode;
  logic             cfg_relu;
  logic             cfg_bcast;
  logic [DW-1:0]    cfg_bsc;
  logic [4:0]       cfg_shift;
  logic [CNT_W-1:0] cfg_pix;
  logic             busy;
  logic             done;
  logic             sat_flag;

  int n_checks = 0;
  int n_err    = 0;

  logic [W-1:0] a_beats[$];
  logic [W-1:0] b_beats[$];
  logic [W-1:0] exp_beats[$];
  vec_t         vt[14];

  elementwise_stream_engine_if #(.LANES(LANES), .DW(DW)) bus ();

  elementwise_stream_engine #(.LANES(LANES), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (cfg_mode),
    .relu_en   (cfg_relu),
    .b_bcast   (cfg_bcast),
    .b_scalar  (cfg_bsc),
    .mul_shift (cfg_shift),
    .pix_cnt   (cfg_pix),
    .strm      (bus),
    .busy      (busy),
    .done      (done),
    .sat_flag  (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [2:0] m, input logic r, input logic bc,
                          input logic [15:0] bs, input logic [4:0] sh, input int pix);
    @(negedge clk);
    cfg_mode  = m;
    cfg_relu  = r;
    cfg_bcast = bc;
    cfg_bsc   = bs;
    cfg_shift = sh;
    cfg_pix   = CNT_W'(pix);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    // scramble live config to show only the launch values matter
    cfg_mode  = 3'd7;
    cfg_relu  = ~r;
    cfg_shift = 5'd3;
  endtask

  // Cycle k: inputs set at negedge k, sampled 1 time unit later; handshakes land on the next posedge.
  task automatic run_stream(input int npix, input int bdelay, input bit rnd_ready, input bit bc,
                            output int done_cyc, output int first_a, output int first_o,
                            output int last_o);
    int           a_idx = 0;
    int           o_idx = 0;
    int           dones = 0;
    bit           prev_stall = 0;
    logic [W-1:0] prev_data = '0;
    logic         prev_last = 1'b0;
    done_cyc = -1;
    first_a  = -1;
    first_o  = -1;
    last_o   = -1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      bus.a_valid = (a_idx < npix);
      bus.a_data  = (a_idx < npix) ? a_beats[a_idx] : '0;
      bus.b_valid = !bc && (a_idx < npix) && (cyc >= bdelay);
      bus.b_data  = (!bc && a_idx < npix) ? b_beats[a_idx] : '0;
      bus.o_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 0) check("busy_after_start", busy, (npix > 0) ? 1 : 0);
      if (bc) check("b_ready_bcast", bus.b_ready, 0);
      if (prev_stall) begin
        check("hold_valid", bus.o_valid, 1);
        check("hold_data", bus.o_data, prev_data);
        check("hold_last", bus.o_last, prev_last);
      end
      if (bus.a_valid && bus.a_ready) begin
        if (first_a < 0) first_a = cyc;
        a_idx++;
      end
      if (bus.o_valid && bus.o_ready) begin
        if (o_idx < npix) begin
          check("o_data", bus.o_data, exp_beats[o_idx]);
          check("o_last", bus.o_last, (o_idx == npix - 1) ? 1 : 0);
        end else begin
          check("extra_beat", 1, 0);
        end
        if (first_o < 0) first_o = cyc;
        last_o = cyc;
        o_idx++;
      end
      prev_stall = bus.o_valid && !bus.o_ready;
      prev_data  = bus.o_data;
      prev_last  = bus.o_last;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    check("done_seen", (done_cyc >= 0) ? 1 : 0, 1);
    check("beats_out", o_idx, npix);
    check("done_pulses", dones, 1);
    bus.o_ready = 1'b1;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    int dc, fa, fo, lo;
    do_start(v.mode, v.relu, v.bcast, v.bsc, v.sh, 1);
    a_beats.delete();
    b_beats.delete();
    exp_beats.delete();
    a_beats.push_back({LANES{v.a}});
    b_beats.push_back({LANES{v.b}});
    exp_beats.push_back({LANES{v.exp}});
    run_stream(1, 0, 0, v.bcast, dc, fa, fo, lo);
    check("sat_flag", sat_flag, v.sat);
    $display("vec %0d mode=%0d a=%h b=%h -> lane0=%h sat=%0b", idx, v.mode, v.a,
             v.bcast ? v.bsc : v.b, bus.o_data[15:0], sat_flag);
  endtask

  initial begin
    int dc, fa, fo, lo;
    logic [W-1:0] av, bv, ev;

    //          mode    relu  bc    bsc       sh     a         b         exp       sat
    vt[0]  = '{EW_ADD, 1'b0, 1'b0, 16'h0000, 5'd0, 16'h0003, 16'h0005, 16'h0008, 1'b0};
    vt[1]  = '{EW_SUB, 1'b0, 1'b0, 16'h0000, 5'd0, 16'h8000, 16'h0001, 16'h8000, 1'b1};
    vt[2]  = '{EW_ADD, 1'b0, 1'b0, 16'h0000, 5'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1};
    vt[3]  = '{EW_MUL, 1'b0, 1'b0, 16'h0000, 5'd8, 16'h0180, 16'h0200, 16'h0300, 1'b0};
    vt[4]  = '{EW_MUL, 1'b0, 1'b0, 16'h0000, 5'd8, 16'h0001, 16'h0080, 16'h0001, 1'b0};
    vt[5]  = '{EW_ADD, 1'b1, 1'b1, 16'hFFFF, 5'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vt[6]  = '{EW_MAX, 1'b0, 1'b0, 16'h0000, 5'd0, 16'hFFFE, 16'h0003, 16'h0003, 1'b0};
    vt[7]  = '{EW_MIN, 1'b0, 1'b0, 16'h0000, 5'd0, 16'hFFFE, 16'h0003, 16'hFFFE, 1'b0};
    vt[8]  = '{3'd7,   1'b0, 1'b0, 16'h0000, 5'd0, 16'h1234, 16'h0001, 16'h1234, 1'b0};
    vt[9]  = '{EW_MUL, 1'b0, 1'b0, 16'h0000, 5'd0, 16'h0100, 16'h0100, 16'h7FFF, 1'b1};
    vt[10] = '{EW_SUB, 1'b1, 1'b0, 16'h0000, 5'd0, 16'h0002, 16'h0005, 16'h0000, 1'b0};
    vt[11] = '{EW_MUL, 1'b0, 1'b0, 16'h0000, 5'd1, 16'hFFFF, 16'h0003, 16'hFFFF, 1'b0};
    vt[12] = '{EW_MUL, 1'b0, 1'b1, 16'h0002, 5'd0, 16'h0010, 16'h0000, 16'h0020, 1'b0};
    vt[13] = '{EW_ADD, 1'b1, 1'b0, 16'h0000, 5'd0, 16'h0010, 16'h0020, 16'h0030, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    cfg_mode = '0; cfg_relu = 1'b0; cfg_bcast = 1'b0; cfg_bsc = '0; cfg_shift = '0; cfg_pix = '0;
    bus.a_valid = 1'b0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_data = '0;
    bus.o_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_o_valid", bus.o_valid, 0);
    check("rst_o_last", bus.o_last, 0);
    check("rst_o_data", bus.o_data, 0);
    check("rst_a_ready", bus.a_ready, 0);
    check("rst_b_ready", bus.b_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat_flag", sat_flag, 0);

    for (int i = 0; i < 14; i++) apply_vec(i, vt[i]);

    // four-beat add run: latency 2, o_last on beat 4, done one cycle after the last handshake
    do_start(EW_ADD, 1'b0, 1'b0, 16'h0, 5'd0, 4);
    a_beats.delete(); b_beats.delete(); exp_beats.delete();
    for (int k = 0; k < 4; k++) begin
      a_beats.push_back({LANES{16'h0003}});
      b_beats.push_back({LANES{16'h0005}});
      exp_beats.push_back({LANES{16'h0008}});
    end
    run_stream(4, 0, 0, 0, dc, fa, fo, lo);
    check("first_accept_cycle", fa, 0);
    check("latency", fo - fa, 2);
    check("throughput", lo - fo, 3);
    check("done_after_last", dc - lo, 1);
    $display("run4 add: first_out=%0d last_out=%0d done=%0d", fo, lo, dc);

    // backpressure run with B delayed 3 cycles and distinct per-lane data
    do_start(EW_ADD, 1'b0, 1'b0, 16'h0, 5'd0, 6);
    a_beats.delete(); b_beats.delete(); exp_beats.delete();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < LANES; i++) begin
        av[i*DW +: DW] = 16'(k * 64 + i);
        bv[i*DW +: DW] = 16'(i * 2 + k + 1);
        ev[i*DW +: DW] = 16'(k * 64 + i) + 16'(i * 2 + k + 1);
      end
      a_beats.push_back(av);
      b_beats.push_back(bv);
      exp_beats.push_back(ev);
    end
    run_stream(6, 3, 1, 0, dc, fa, fo, lo);
    check("bdelay_first_accept", (fa >= 3) ? 1 : 0, 1);
    check("bp_sat_flag", sat_flag, 0);
    $display("run6 backpressure: first_accept=%0d done=%0d", fa, dc);

    // empty run goes straight to DONE
    do_start(EW_ADD, 1'b0, 1'b0, 16'h0, 5'd0, 0);
    a_beats.delete(); b_beats.delete(); exp_beats.delete();
    run_stream(0, 0, 0, 0, dc, fa, fo, lo);
    check("pix0_done_cycle", dc, 0);
    check("pix0_no_output", (fo < 0) ? 1 : 0, 1);
    $display("run0 empty: done=%0d", dc);

    // reset in the middle of a saturating run
    do_start(EW_SUB, 1'b0, 1'b0, 16'h0, 5'd0, 8);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.a_valid = 1'b1; bus.a_data = {LANES{16'h8000}};
      bus.b_valid = 1'b1; bus.b_data = {LANES{16'h0001}};
      bus.o_ready = 1'b1;
    end
    #1;
    check("mid_sat_flag", sat_flag, 1);
    check("mid_busy", busy, 1);
    check("mid_o_valid", bus.o_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_o_valid", bus.o_valid, 0);
    check("arst_o_data", bus.o_data, 0);
    check("arst_o_last", bus.o_last, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sat_flag", sat_flag, 0);
    check("arst_a_ready", bus.a_ready, 0);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_done", done, 0);
    $display("reset mid-run: outputs cleared");
    apply_vec(99, vt[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
